bd_in_handshaker: RTL and testbench

BD_IN_HANDSHAKER -- requirements
Module: bd_in_handshaker

---
 rtl/bd_in_handshaker_pkg.sv | 18 +
 rtl/bd_sync2.sv | 23 ++
 rtl/bd_in_handshaker.sv | 91 +++++++++
 tb/tb_bd_in_handshaker.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bd_in_handshaker_pkg.sv
// Shared BD input-side definitions: encoded word width and handshake FSM state encoding.
// BDEncoder sizes its output from NBD_DATA so both ends of the link agree.
package bd_in_handshaker_pkg;

  localparam int NBD_DATA = 21;

  typedef logic [1:0] bd_state_t;

  localparam bd_state_t ST_IDLE        = 2'd0;
  localparam bd_state_t ST_SETUP       = 2'd1;
  localparam bd_state_t ST_WAIT_ACK_HI = 2'd2;
  localparam bd_state_t ST_WAIT_ACK_LO = 2'd3;

  function automatic logic is_wait_state(input bd_state_t s);
    return (s == ST_WAIT_ACK_HI) || (s == ST_WAIT_ACK_LO);
  endfunction

endpackage

// File: rtl/bd_sync2.sv
// Two-flop synchronizer for signals arriving from the BD chip's clockless domain.
module bd_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (!reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/bd_in_handshaker.sv
// Pushes encoded words to the BD chip over a four-phase req/ack link with a data setup
// window, a sticky ack timeout flag and a count of completed handshakes.
//
// state          | meaning
// ST_IDLE        | ready for a word, words_in_a = 1
// ST_SETUP       | bd_data driven, waiting setup window and ack low
// ST_WAIT_ACK_HI | bd_req = 1, waiting for ack to rise
// ST_WAIT_ACK_LO | bd_req = 0, waiting for ack to fall
module bd_in_handshaker
  import bd_in_handshaker_pkg::*;
#(
  parameter int NBDdata        = NBD_DATA,
  parameter int SETUP_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NBDdata-1:0] words_in_d,
  input  logic               words_in_v,
  output logic               words_in_a,
  output logic [NBDdata-1:0] bd_data,
  output logic               bd_req,
  input  logic               bd_ack,
  output logic               timeout_err,
  output logic [31:0]        words_sent
);

  localparam int SCW = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
  localparam int TCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [SCW-1:0] SETUP_LAST = SCW'(SETUP_CYCLES - 1);
  localparam logic [TCW-1:0] TMO_LAST   = TCW'(TIMEOUT_CYCLES - 1);

  bd_state_t      state;
  bd_state_t      state_nxt;
  logic           ack_s;
  logic [SCW-1:0] setup_cnt;
  logic [TCW-1:0] tmo_cnt;
  logic           xfer;

  bd_sync2 #(.WIDTH(1)) u_ack_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bd_ack),
    .q     (ack_s)
  );

  assign words_in_a = reset && (state == ST_IDLE);
  assign xfer       = words_in_v && words_in_a;

  // SETUP only leaves once ack is low, so a stale ack from the previous word cannot
  // be mistaken for the acknowledge of this one.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:        if (xfer) state_nxt = ST_SETUP;
      ST_SETUP:       if ((setup_cnt == SETUP_LAST) && !ack_s) state_nxt = ST_WAIT_ACK_HI;
      ST_WAIT_ACK_HI: if (ack_s) state_nxt = ST_WAIT_ACK_LO;
      ST_WAIT_ACK_LO: if (!ack_s) state_nxt = ST_IDLE;
      default:        state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_IDLE;
      bd_req      <= 1'b0;
      bd_data     <= '0;
      setup_cnt   <= '0;
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
      words_sent  <= '0;
    end else begin
      state  <= state_nxt;
      bd_req <= (state_nxt == ST_WAIT_ACK_HI);

      if (xfer) bd_data <= words_in_d;

      if (state != ST_SETUP)        setup_cnt <= '0;
      else if (setup_cnt != SETUP_LAST) setup_cnt <= setup_cnt + SCW'(1);

      // Timeout only flags; the FSM keeps waiting so no word is dropped.
      if ((state_nxt != state) && is_wait_state(state_nxt)) tmo_cnt <= '0;
      else if (is_wait_state(state) && (tmo_cnt != TMO_LAST)) tmo_cnt <= tmo_cnt + TCW'(1);

      if (is_wait_state(state) && (tmo_cnt == TMO_LAST)) timeout_err <= 1'b1;

      if ((state == ST_WAIT_ACK_LO) && !ack_s) words_sent <= words_sent + 32'd1;
    end
  end

endmodule

// File: tb/tb_bd_in_handshaker.sv
// Directed bench for bd_in_handshaker: reset, single word, back-to-back, stuck ack,
// ack high at accept, mid-handshake reset and words_sent wrap.
module tb_bd_in_handshaker;
  import bd_in_handshaker_pkg::*;

  localparam int W = NBD_DATA;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] words_in_d = '0;
  logic         words_in_v = 1'b0;
  logic         words_in_a;
  logic [W-1:0] bd_data;
  logic         bd_req;
  logic         bd_ack;
  logic         timeout_err;
  logic [31:0]  words_sent;

  logic         ack_mode = 1'b0;
  logic         ack_manual = 1'b0;
  logic [2:0]   ack_dly = '0;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_sent = 0;

  bd_in_handshaker #(.NBDdata(W), .SETUP_CYCLES(2), .TIMEOUT_CYCLES(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .words_in_d  (words_in_d),
    .words_in_v  (words_in_v),
    .words_in_a  (words_in_a),
    .bd_data     (bd_data),
    .bd_req      (bd_req),
    .bd_ack      (bd_ack),
    .timeout_err (timeout_err),
    .words_sent  (words_sent)
  );

  always #5 clk = ~clk;

  // Loopback mode: ack follows req three cycles later.
  always @(posedge clk) ack_dly <= {ack_dly[1:0], bd_req};
  assign bd_ack = ack_mode ? ack_dly[2] : ack_manual;

  function automatic logic cur(input int sel);
    case (sel)
      0:       return words_in_a;
      1:       return bd_req;
      default: return bd_ack;
    endcase
  endfunction

  task automatic wait_for(input int sel, input logic val, output bit ok);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (cur(sel) === val) begin
        ok = 1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_word(input logic [W-1:0] w, output bit ok);
    bit o1, o2, o3, o4;
    wait_for(0, 1'b1, o1);
    words_in_d = w;
    words_in_v = 1'b1;
    @(negedge clk);
    words_in_v = 1'b0;
    wait_for(1, 1'b1, o2);
    wait_for(1, 1'b0, o3);
    wait_for(0, 1'b1, o4);
    ok = o1 && o2 && o3 && o4;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bd_req !== 1'b0) begin errors++; $display("FAIL reset_bd_req: got %b want 0", bd_req); end
    checks++; if (bd_data !== '0) begin errors++; $display("FAIL reset_bd_data: got %h want 0", bd_data); end
    checks++; if (words_in_a !== 1'b0) begin errors++; $display("FAIL reset_a: got %b want 0", words_in_a); end
    checks++; if (words_sent !== 32'd0) begin errors++; $display("FAIL reset_sent: got %0d want 0", words_sent); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", timeout_err); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (words_in_a !== 1'b1) begin errors++; $display("FAIL reset_release_a: got %b want 1", words_in_a); end
  endtask

  task automatic test_single_word();
    bit ok;
    ack_mode = 1'b1;
    wait_for(0, 1'b1, ok);
    words_in_d = 21'h15A5A5;
    words_in_v = 1'b1;
    @(negedge clk);
    words_in_v = 1'b0;
    checks++; if (bd_data !== 21'h15A5A5) begin errors++; $display("FAIL single_data_t1: got %h want 15a5a5", bd_data); end
    checks++; if (words_in_a !== 1'b0) begin errors++; $display("FAIL single_a_t1: got %b want 0", words_in_a); end
    checks++; if (bd_req !== 1'b0) begin errors++; $display("FAIL single_req_t1: got %b want 0", bd_req); end
    @(negedge clk);
    checks++; if (bd_req !== 1'b0) begin errors++; $display("FAIL single_req_t2: got %b want 0", bd_req); end
    @(negedge clk);
    checks++; if (bd_req !== 1'b1) begin errors++; $display("FAIL single_req_t3: got %b want 1", bd_req); end
    wait_for(2, 1'b1, ok);
    checks++; if (!ok || bd_req !== 1'b1) begin errors++; $display("FAIL single_ack_rise: ok %b req %b want 1 1", ok, bd_req); end
    wait_for(1, 1'b0, ok);
    checks++; if (!ok || bd_ack !== 1'b1) begin errors++; $display("FAIL single_req_fall: ok %b ack %b want 1 1", ok, bd_ack); end
    wait_for(0, 1'b1, ok);
    exp_sent = exp_sent + 1;
    checks++; if (!ok || bd_ack !== 1'b0) begin errors++; $display("FAIL single_idle: ok %b ack %b want 1 0", ok, bd_ack); end
    checks++; if (words_sent !== exp_sent) begin errors++; $display("FAIL single_sent: got %0d want %0d", words_sent, exp_sent); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL single_err: got %b want 0", timeout_err); end
    checks++; if (bd_data !== 21'h15A5A5) begin errors++; $display("FAIL single_data_hold: got %h want 15a5a5", bd_data); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] words [3];
    int idx;
    bit done;
    words[0] = 21'h0ABCDE;
    words[1] = 21'h1F0F0F;
    words[2] = 21'h000001;
    idx  = 0;
    done = 0;
    ack_mode = 1'b1;
    for (int c = 0; c < 300; c++) begin
      if (idx > 0) begin
        checks++; if (bd_data !== words[idx-1]) begin errors++; $display("FAIL b2b_data: got %h want %h", bd_data, words[idx-1]); end
      end
      if (idx == 3 && words_in_a === 1'b1) begin
        done = 1;
        break;
      end
      words_in_v = (idx < 3);
      if (idx < 3) words_in_d = words[idx];
      if (idx < 3 && words_in_a === 1'b1) begin
        checks++; if (bd_ack !== 1'b0) begin errors++; $display("FAIL b2b_ack_low_at_accept: got %b want 0", bd_ack); end
        idx++;
      end
      @(negedge clk);
    end
    words_in_v = 1'b0;
    exp_sent = exp_sent + 3;
    checks++; if (!done) begin errors++; $display("FAIL b2b_done: got %0d accepts want 3", idx); end
    checks++; if (words_sent !== exp_sent) begin errors++; $display("FAIL b2b_sent: got %0d want %0d", words_sent, exp_sent); end
  endtask

  task automatic test_stuck_ack();
    bit ok;
    ack_mode = 1'b0;
    ack_manual = 1'b0;
    wait_for(0, 1'b1, ok);
    words_in_d = 21'h0C3C3C;
    words_in_v = 1'b1;
    @(negedge clk);
    words_in_v = 1'b0;
    wait_for(1, 1'b1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stuck_req_rise: got %b want 1", bd_req); end
    repeat (15) @(negedge clk);
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL stuck_err_early: got %b want 0", timeout_err); end
    @(negedge clk);
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL stuck_err_set: got %b want 1", timeout_err); end
    repeat (20) @(negedge clk);
    checks++; if (bd_req !== 1'b1 || words_in_a !== 1'b0) begin errors++; $display("FAIL stuck_still_waiting: req %b a %b want 1 0", bd_req, words_in_a); end
    ack_manual = 1'b1;
    wait_for(1, 1'b0, ok);
    ack_manual = 1'b0;
    wait_for(0, 1'b1, ok);
    exp_sent = exp_sent + 1;
    checks++; if (words_sent !== exp_sent) begin errors++; $display("FAIL stuck_sent: got %0d want %0d", words_sent, exp_sent); end
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL stuck_err_sticky: got %b want 1", timeout_err); end
  endtask

  task automatic test_ack_high_at_accept();
    bit ok;
    ack_mode = 1'b0;
    ack_manual = 1'b1;
    repeat (3) @(negedge clk);
    wait_for(0, 1'b1, ok);
    words_in_d = 21'h1234AB;
    words_in_v = 1'b1;
    @(negedge clk);
    words_in_v = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (bd_req !== 1'b0) begin errors++; $display("FAIL ackhi_req_held_%0d: got %b want 0", i, bd_req); end
      @(negedge clk);
    end
    ack_manual = 1'b0;
    @(negedge clk);
    checks++; if (bd_req !== 1'b0) begin errors++; $display("FAIL ackhi_req_p1: got %b want 0", bd_req); end
    @(negedge clk);
    checks++; if (bd_req !== 1'b0) begin errors++; $display("FAIL ackhi_req_p2: got %b want 0", bd_req); end
    @(negedge clk);
    checks++; if (bd_req !== 1'b1) begin errors++; $display("FAIL ackhi_req_p3: got %b want 1", bd_req); end
    ack_manual = 1'b1;
    wait_for(1, 1'b0, ok);
    ack_manual = 1'b0;
    wait_for(0, 1'b1, ok);
    exp_sent = exp_sent + 1;
    checks++; if (words_sent !== exp_sent) begin errors++; $display("FAIL ackhi_sent: got %0d want %0d", words_sent, exp_sent); end
  endtask

  task automatic test_mid_reset();
    bit ok;
    ack_mode = 1'b1;
    wait_for(0, 1'b1, ok);
    words_in_d = 21'h0F00F0;
    words_in_v = 1'b1;
    @(negedge clk);
    words_in_v = 1'b0;
    wait_for(1, 1'b1, ok);
    wait_for(1, 1'b0, ok);
    checks++; if (!ok || words_in_a !== 1'b0) begin errors++; $display("FAIL midrst_in_lo: ok %b a %b want 1 0", ok, words_in_a); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (bd_req !== 1'b0) begin errors++; $display("FAIL midrst_req: got %b want 0", bd_req); end
    checks++; if (words_sent !== 32'd0) begin errors++; $display("FAIL midrst_sent: got %0d want 0", words_sent); end
    checks++; if (words_in_a !== 1'b0) begin errors++; $display("FAIL midrst_a: got %b want 0", words_in_a); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL midrst_err: got %b want 0", timeout_err); end
    reset = 1'b1;
    exp_sent = 0;
    run_word(21'h1ACE01, ok);
    exp_sent = exp_sent + 1;
    checks++; if (!ok) begin errors++; $display("FAIL midrst_next_word: got ok %b want 1", ok); end
    checks++; if (words_sent !== exp_sent) begin errors++; $display("FAIL midrst_next_sent: got %0d want %0d", words_sent, exp_sent); end
    checks++; if (bd_data !== 21'h1ACE01) begin errors++; $display("FAIL midrst_next_data: got %h want 1ace01", bd_data); end
  endtask

  task automatic test_wrap();
    bit ok;
    ack_mode = 1'b1;
    force dut.words_sent = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.words_sent;
    @(negedge clk);
    checks++; if (words_sent !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_preload: got %h want ffffffff", words_sent); end
    run_word(21'h055555, ok);
    checks++; if (!ok || words_sent !== 32'd0) begin errors++; $display("FAIL wrap_sent: ok %b got %h want 1 00000000", ok, words_sent); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_stuck_ack();
    test_ack_high_at_accept();
    test_mid_reset();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
